// File: rtl/dac_pkg.sv
// dac_pkg: shared types and word format for the DAC update sequencer.
//   state_t  : sequencer FSM states
//   mk_word  : builds the 16-bit serializer word {2'b00, ch[1:0], code[11:0]}
package dac_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    GAP  = 1'b1
  } state_t;

  localparam int WORD_W   = 16;
  localparam int CODE_W   = 12;
  localparam int CH_W     = 2;
  localparam int CODE_LSB = 0;
  localparam int ADDR_LSB = 12;

  // Bits 15:14 stay zero; the serializer treats them as reserved.
  function automatic logic [WORD_W-1:0] mk_word(input logic [CH_W-1:0]   ch,
                                                input logic [CODE_W-1:0] code);
    logic [WORD_W-1:0] w;
    w = '0;
    w[ADDR_LSB +: CH_W]   = ch;
    w[CODE_LSB +: CODE_W] = code;
    return w;
  endfunction

endpackage

// File: rtl/dac_seq_rr_arb.sv
// rr_arb: combinational round-robin arbiter.
//   req     : per-channel request bits
//   last    : most recently granted channel; search starts at last+1
//   gnt_idx : granted channel (valid when gnt_any)
//   gnt_any : at least one request present
module rr_arb
  import dac_pkg::*;
#(
  parameter int NCH = 4
) (
  input  logic [NCH-1:0]  req,
  input  logic [CH_W-1:0] last,
  output logic [CH_W-1:0] gnt_idx,
  output logic            gnt_any
);

  // Distance of channel c from the search start (last+1), modulo NCH.
  // The requester with the smallest distance wins.
  int best_d;
  int d;

  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    best_d  = NCH;
    d       = 0;
    for (int c = 0; c < NCH; c++) begin
      d = c - int'(last) - 1;
      if (d < 0) d = d + NCH;
      if (req[c] && (d < best_d)) begin
        best_d  = d;
        gnt_idx = CH_W'(c);
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dac_seq.sv
// dac_seq: multi-channel update sequencer feeding a serial DAC controller.
//   clk, rst      : clock, asynchronous active-high reset
//   wr_en/ch/data : channel code write; marks the channel pending
//   upd_all       : mark every channel pending (codes unchanged)
//   din, din_vld  : word and one-cycle strobe toward the serializer
//   busy          : frame gap running
//   done          : pulse in the last cycle of a frame gap
//   pend          : pending bits (status)
module dac_seq
  import dac_pkg::*;
#(
  parameter int NCH          = 4,
  parameter int DW           = 12,
  parameter int FRAME_CYCLES = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [DW-1:0]     wr_data,
  input  logic              upd_all,
  output logic [WORD_W-1:0] din,
  output logic              din_vld,
  output logic              busy,
  output logic              done,
  output logic [NCH-1:0]    pend
);

  state_t                state, state_nxt;
  logic [NCH-1:0][DW-1:0] code;
  logic [CH_W-1:0]       last;
  logic [7:0]            cnt;
  logic [CH_W-1:0]       gnt_idx;
  logic                  gnt_any;
  logic                  take;
  logic                  wr_ok;
  logic [DW-1:0]         sel_code;

  // Writes to channels beyond NCH are dropped.
  assign wr_ok = wr_en && ({1'b0, wr_ch} < 3'(NCH));

  rr_arb #(.NCH(NCH)) u_arb (
    .req     (pend),
    .last    (last),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_any) state_nxt = GAP;
      GAP:     if (cnt == 8'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy = (state == GAP);
    take = (state == IDLE) && gnt_any;
  end

  // Granted code mux.
  always_comb begin
    sel_code = '0;
    for (int c = 0; c < NCH; c++)
      if (gnt_idx == CH_W'(c)) sel_code = code[c];
  end

  // Code registers and pending bits. A write or upd_all in the same edge
  // as a grant overrides the clear, so the channel goes out again later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code <= '0;
      pend <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (wr_ok && (wr_ch == CH_W'(c))) code[c] <= wr_data;
        if (upd_all || (wr_ok && (wr_ch == CH_W'(c))))
          pend[c] <= 1'b1;
        else if (take && (gnt_idx == CH_W'(c)))
          pend[c] <= 1'b0;
      end
    end
  end

  // Issue datapath and gap counter. din is only reloaded on a grant so it
  // holds the last word between frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din     <= '0;
      din_vld <= 1'b0;
      done    <= 1'b0;
      cnt     <= '0;
      last    <= CH_W'(NCH - 1);
    end else begin
      din_vld <= take;
      // Registered off cnt==1 so the pulse lands in the gap's final cycle.
      done    <= (state == GAP) && (cnt == 8'd1);
      if (take) begin
        din  <= mk_word(gnt_idx, sel_code);
        last <= gnt_idx;
        cnt  <= 8'(FRAME_CYCLES - 1);
      end else if ((state == GAP) && (cnt != 8'd0)) begin
        cnt <= cnt - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_dac_seq.sv
// tb_dac_seq: scoreboard bench for dac_seq (NCH=4 main instance, NCH=3
// instance for the out-of-range channel case).
module tb_dac_seq;
  import dac_pkg::*;

  localparam int FC  = 40;
  localparam int FC3 = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, upd_all;
  logic [1:0]  wr_ch;
  logic [11:0] wr_data;
  logic [15:0] din;
  logic        din_vld, busy, done;
  logic [3:0]  pend;

  logic        w3_en, upd3;
  logic [1:0]  w3_ch;
  logic [11:0] w3_data;
  logic [15:0] din3;
  logic        vld3, busy3, done3;
  logic [2:0]  pend3;

  always #5 clk = ~clk;

  dac_seq #(.NCH(4), .DW(12), .FRAME_CYCLES(FC)) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
    .upd_all(upd_all), .din(din), .din_vld(din_vld), .busy(busy),
    .done(done), .pend(pend)
  );

  dac_seq #(.NCH(3), .DW(12), .FRAME_CYCLES(FC3)) u_dut3 (
    .clk(clk), .rst(rst), .wr_en(w3_en), .wr_ch(w3_ch), .wr_data(w3_data),
    .upd_all(upd3), .din(din3), .din_vld(vld3), .busy(busy3),
    .done(done3), .pend(pend3)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int vld_n  = 0;
  int vld3_n = 0;
  int blen   = 0;
  int dpos   = 0;
  int dcnt   = 0;
  int done_total = 0;
  int wr_cyc = 0;
  int vtimes[$];
  logic [15:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard / gap monitor for the main instance.
  always @(negedge clk) begin
    if (!rst) begin
      if (din_vld) begin
        vld_n++;
        vtimes.push_back(cyc);
        if (exp_q.size() == 0) chk("unexpected_vld", 1, 0);
        else                   chk("word", din, exp_q.pop_front());
        blen = 1; dpos = 0; dcnt = 0;
      end else if (busy) begin
        blen++;
      end
      if (done) begin
        dcnt++; dpos = blen; done_total++;
      end
      if (vld3) vld3_n++;
    end
  end

  // Drive a write for the next edge; consecutive calls give back-to-back writes.
  task automatic wr(input int ch, input logic [11:0] d, input bit expect_word);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_ch = 2'(ch); wr_data = d;
    if (expect_word) exp_q.push_back(mk_word(2'(ch), d));
  endtask

  task automatic wr_done();
    @(posedge clk); #1;
    wr_cyc = cyc;
    wr_en  = 1'b0;
  endtask

  task automatic wait_vld(input int target, input string tag);
    int n;
    n = 0;
    while (vld_n < target && n < 1000) begin
      @(negedge clk); #1; n++;
    end
    if (vld_n < target) chk({"timeout_", tag}, 0, 1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while ((busy || pend != 0 || din_vld || exp_q.size() != 0) && n < 1000);
    if (n >= 1000) chk({"timeout_", tag}, 0, 1);
  endtask

  initial begin
    int n0, t0, d0, n;
    rst = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_data = '0; upd_all = 1'b0;
    w3_en = 1'b0; w3_ch = '0; w3_data = '0; upd3 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_din", din, 16'h0000);
    chk("rst_vld", din_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pend", pend, 0);
    chk("rst_pend3", pend3, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Single write: latency, busy length, done position.
    n0 = vld_n;
    wr(2, 12'hABC, 1); wr_done(); t0 = wr_cyc;
    wait_vld(n0 + 1, "t1");
    chk("t1_latency", vtimes[n0] - t0, 1);
    wait_idle("t1");
    chk("t1_busy_len", blen, FC);
    chk("t1_done_pos", dpos, FC);
    chk("t1_done_cnt", dcnt, 1);

    // Back-to-back writes ch3, ch0, ch1.
    n0 = vld_n;
    wr(3, 12'h111, 1); wr(0, 12'h222, 1); wr(1, 12'h333, 1); wr_done();
    t0 = wr_cyc - 2;
    wait_vld(n0 + 3, "t2");
    chk("t2_first", vtimes[n0] - t0, 1);
    chk("t2_gap1", vtimes[n0+1] - vtimes[n0], FC + 1);
    chk("t2_gap2", vtimes[n0+2] - vtimes[n0+1], FC + 1);
    wait_idle("t2");

    // Rewrite during the gap: word in flight unchanged.
    n0 = vld_n;
    wr(1, 12'h444, 1); wr_done();
    wait_vld(n0 + 1, "t3a");
    repeat (5) @(negedge clk);
    wr(1, 12'h555, 1); wr_done();
    @(negedge clk); #1;
    chk("t3_hold_a", din, 16'h1444);
    chk("t3_pend", pend, 4'b0010);
    repeat (20) @(negedge clk);
    chk("t3_hold_b", din, 16'h1444);
    wait_vld(n0 + 2, "t3b");
    chk("t3_gap", vtimes[n0+1] - vtimes[n0], FC + 1);
    wait_idle("t3");

    // Load codes, then upd_all resends all four in channel order.
    wr(0, 12'h010, 1); wr(1, 12'h020, 1); wr(2, 12'h030, 1); wr(3, 12'h040, 1);
    wr_done();
    wait_idle("t4a");
    n0 = vld_n;
    @(posedge clk); #1 upd_all = 1'b1;
    exp_q.push_back(16'h0010); exp_q.push_back(16'h1020);
    exp_q.push_back(16'h2030); exp_q.push_back(16'h3040);
    @(posedge clk); #1 upd_all = 1'b0;
    @(negedge clk); #1;
    chk("t4_pend_all", pend, 4'hF);
    wait_vld(n0 + 4, "t4");
    chk("t4_pend_clr", pend, 4'h0);
    wait_idle("t4b");

    // Write colliding with a grant of the same channel: sent twice.
    n0 = vld_n;
    wr(0, 12'h777, 1); wr(0, 12'h778, 1); wr_done();
    wait_idle("t5");
    chk("t5_count", vld_n - n0, 2);

    // NCH=3: channel 3 write is ignored, channel 2 works.
    @(posedge clk); #1 w3_en = 1'b1; w3_ch = 2'd3; w3_data = 12'hFFF;
    @(posedge clk); #1 w3_en = 1'b0;
    repeat (30) @(negedge clk);
    chk("n3_pend", pend3, 0);
    chk("n3_novld", vld3_n, 0);
    @(posedge clk); #1 w3_en = 1'b1; w3_ch = 2'd2; w3_data = 12'h5A5;
    @(posedge clk); #1 w3_en = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!vld3 && n < 100);
    chk("n3_word", din3, 16'h25A5);

    // Reset mid-gap.
    n0 = vld_n;
    wr(0, 12'h0AB, 1); wr_done();
    wait_vld(n0 + 1, "t6");
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("t6_din", din, 16'h0000);
    chk("t6_busy", busy, 0);
    chk("t6_vld", din_vld, 0);
    chk("t6_pend", pend, 0);
    d0 = done_total;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (100) @(negedge clk);
    chk("t6_no_vld", vld_n, n0 + 1);
    chk("t6_no_done", done_total, d0);
    chk("sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dac_seq.md
# dac_seq

Multi-channel update sequencer in front of the serial DAC controller. Holds one 12-bit code per DAC channel and marks a channel pending on every write. A round-robin scheduler issues pending channels, one 16-bit word at a time, on the controller's `din`/`din_vld` input. Words are spaced by a fixed frame gap because the serializer has no busy/ready return.

## Interface
- `NCH`, default 4: number of DAC channels, 1..4.
- `DW`, default 12: code width per channel; fixed at 12 by the word format.
- `FRAME_CYCLES`, default 40: minimum clk cycles between consecutive `din_vld` pulses. Must cover the serializer's full cs/sclk/ldac frame. Legal range 2..255.

Ports:
- `clk`  in  1: system clock (50 MHz).
- `rst`  in  1: asynchronous, active-high reset.
- `wr_en`  in  1: write strobe for the channel code register.
- `wr_ch`  in  2: target channel. Writes with `wr_ch >= NCH` are ignored.
- `wr_data`  in  12: new channel code.
- `upd_all`  in  1: one-cycle request to mark every channel pending. Codes are not changed.
- `din`  out  16: word to the serializer, `{2'b00, ch[1:0], code[11:0]}`.
- `din_vld`  out  1: one-cycle strobe. `din` is valid in the same cycle.
- `busy`  out  1: high while a frame gap is running.
- `done`  out  1: one-cycle pulse in the last cycle of a frame gap.
- `pend`  out  NCH: current pending bits; debug and status only.

## Operation
- Reset state of all outputs and state:
  - `din=16'h0000`, `din_vld=0`, `busy=0`, `done=0`, `pend=0`.
  - All code registers 0; round-robin pointer `last=NCH-1`, so ch0 has first priority.
  - FSM in IDLE.
- Write: when `wr_en` is high, `code[wr_ch]<=wr_data` and `pend[wr_ch]<=1`.
- `upd_all`: `pend<= all ones`.
- FSM states:
  - IDLE: if `pend != 0`, grant the first pending channel searching `last+1, last+2, …` modulo NCH. In that same edge:
    - load `din` from the granted code,
    - set `din_vld=1`, clear `pend[grant]`, set `last<=grant`, load `cnt<=FRAME_CYCLES-1`,
    - go to GAP.
  - GAP: `busy=1`. `cnt` decrements each cycle. When `cnt==1`, `done=1` for that cycle. When `cnt==0`, go to IDLE.
- The code is captured into `din` at grant time. Later writes to the same channel do not alter the word in flight.
- `din` holds its last value between grants and is never forced back to 0 except by reset.
- Simultaneous events:
  - A write and a grant on the same channel in the same edge: the write wins. `pend` stays 1 and the channel is sent again later with the new code.
  - `upd_all` together with a grant: `upd_all` wins, and all pending bits are 1 afterwards.
  - `wr_en` together with `upd_all`: both apply.
- Reset asserted mid-gap: all state clears immediately, regardless of clk. Any partial serializer frame is the serializer's concern.

## Timing
- Latency: `wr_en` sampled high at edge k, with the FSM in IDLE and no other channel pending → `din_vld` is high in the cycle after edge k+1, two edges after the write.
- `busy` rises together with `din_vld` and stays high for FRAME_CYCLES cycles, counting the `din_vld` cycle as cycle 1.
- `done` is high in cycle FRAME_CYCLES.
- Next `din_vld`, at the earliest, comes FRAME_CYCLES+1 cycles after the previous one, because there is one IDLE cycle for arbitration.
- Throughput: one word per FRAME_CYCLES+1 cycles while any channel is pending.
- Fairness: with all channels continuously pending, every channel is issued once per NCH words.

## Structure
- Shared package `dac_pkg` contains:
  - the state enum {IDLE, GAP},
  - the word format constants (address field at bits 13:12, code at 11:0, bits 15:14 = 0),
  - a `mk_word(ch, code)` function. The serializer testbench also uses this function.
- Sub-module `rr_arb` is a combinational round-robin arbiter with inputs `req[NCH]` and `last`, and outputs `gnt_idx` and `gnt_any`.
- The top level holds the code registers, pending bits, FSM, and gap counter.

## Test plan
- Write ch2 code `12'hABC` at edge k → `din=16'h2ABC` and `din_vld` high exactly one cycle, two edges after k. `busy` is high for 40 cycles and `done` pulses at cycle 40.
- Back-to-back writes ch3=`12'h111`, ch0=`12'h222`, ch1=`12'h333` → words issued in order `16'h3111`, `16'h0222`, `16'h1333`. The first starts at write+2 and each next `din_vld` is 41 cycles after the previous.
- Rewrite ch1 to `12'h555` during the gap after ch1=`12'h444` was issued → `din` unchanged (`16'h1444`) during the gap, then `16'h1555` is issued after the gap.
- `upd_all` with codes 0x010/0x020/0x030/0x040 → four words in order ch0..ch3: `16'h0010`, `16'h1020`, `16'h2030`, `16'h3040`. `pend` reaches 0 after the fourth grant.
- Write to ch4 with NCH=4 via the 2-bit field overflow case. Run this with NCH=3 and `wr_ch=3` → no `pend` change and no `din_vld`.
- Assert `rst` 10 cycles into a gap → all outputs zero immediately, with no `done` pulse and no further `din_vld` after release until a new write.
